// File: rtl/endian48_pkg.sv
// Shared constants, FSM state type and the 48-bit bit-reversal used by both
// the transmit-side swap and the receive-side unswap.
package endian48_pkg;

  localparam int WORD_W         = 48;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 6;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  function automatic logic [WORD_W-1:0] bit_reverse48(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) begin
      r[i] = w[WORD_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/endian_unswap48_rx_if.sv
// Byte-in / word-out stream bundle; the slave side is the unswap block.
interface endian_unswap48_rx_if;
  import endian48_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [WORD_W-1:0] out_word;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_word, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_word, out_valid
  );
endinterface

// File: rtl/byte_placer48.sv
// Combinational insert of byte idx into a 48-bit word; zero latency, no
// handshake.
module byte_placer48
  import endian48_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic [WORD_W-1:0] word_in,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic [2:0]        idx,
  output logic [WORD_W-1:0] word_out
);

  // Constant slice bounds per lane keep out-of-range indices harmless.
  always_comb begin
    word_out = word_in;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (idx == 3'(k)) begin
        if (MSB_FIRST != 0) begin
          word_out[WORD_W-1-BYTE_W*k -: BYTE_W] = byte_in;
        end else begin
          word_out[BYTE_W*k +: BYTE_W] = byte_in;
        end
      end
    end
  end

endmodule

// File: rtl/endian_unswap48_rx.sv
// Reassembles 6-byte frames into 48-bit words (optionally bit-reversed); word valid
// 1 cycle after the 6th byte. Only the 6th byte stalls while a prior word waits.
module endian_unswap48_rx
  import endian48_pkg::*;
#(
  parameter int MSB_FIRST   = 1,
  parameter int BIT_REVERSE = 1,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  endian_unswap48_rx_if.slave bus,
  output logic               err_short,
  output logic [COUNT_W-1:0] word_count
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD - 1);

  state_t            state, state_n;
  logic [2:0]        idx, idx_n;
  logic [WORD_W-1:0] asm_q, asm_n, placed, final_word, out_q;
  logic              out_vld, ready_en, load_out, err_n, accept, out_acc;

  byte_placer48 #(.MSB_FIRST(MSB_FIRST)) u_placer (
    .word_in  (asm_q),
    .byte_in  (bus.in_data),
    .idx      (idx),
    .word_out (placed)
  );

  assign final_word   = (BIT_REVERSE != 0) ? bit_reverse48(placed) : placed;
  assign bus.in_ready = ready_en && !(idx == LAST_IDX && out_vld && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_acc      = out_vld && bus.out_ready;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    asm_n    = asm_q;
    load_out = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.in_last) begin
            err_n = 1'b1;
          end else begin
            state_n = COLLECT;
            idx_n   = 3'd1;
            asm_n   = placed;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            load_out = 1'b1;
            state_n  = IDLE;
            idx_n    = 3'd0;
            asm_n    = '0;
          end else if (bus.in_last) begin
            err_n   = 1'b1;
            state_n = IDLE;
            idx_n   = 3'd0;
            asm_n   = '0;
          end else begin
            idx_n = idx + 3'd1;
            asm_n = placed;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 3'd0;
      asm_q      <= '0;
      out_q      <= '0;
      out_vld    <= 1'b0;
      ready_en   <= 1'b0;
      err_short  <= 1'b0;
      word_count <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      asm_q     <= asm_n;
      ready_en  <= 1'b1;
      err_short <= err_n;
      // A completing word takes priority so accept+complete reloads with no bubble.
      if (load_out) begin
        out_q   <= final_word;
        out_vld <= 1'b1;
      end else if (out_acc) begin
        out_vld <= 1'b0;
      end
      if (out_acc && word_count != {COUNT_W{1'b1}}) begin
        word_count <= word_count + 1'b1;
      end
    end
  end

  assign bus.out_word  = out_q;
  assign bus.out_valid = out_vld;

endmodule

// File: tb/tb_endian_unswap48_rx.sv
// Directed bench: three configurations (MSB/no-rev, MSB/rev, LSB/no-rev with
// a 2-bit counter) driven by one shared byte stream.
module tb_endian_unswap48_rx;
  import endian48_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic        err_a, err_b, err_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  endian_unswap48_rx_if ifa ();
  endian_unswap48_rx_if ifb ();
  endian_unswap48_rx_if ifc ();

  assign ifa.in_data = in_data;  assign ifa.in_valid = in_valid;
  assign ifa.in_last = in_last;  assign ifa.out_ready = out_ready;
  assign ifb.in_data = in_data;  assign ifb.in_valid = in_valid;
  assign ifb.in_last = in_last;  assign ifb.out_ready = out_ready;
  assign ifc.in_data = in_data;  assign ifc.in_valid = in_valid;
  assign ifc.in_last = in_last;  assign ifc.out_ready = out_ready;

  endian_unswap48_rx #(.MSB_FIRST(1), .BIT_REVERSE(0), .COUNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .err_short(err_a), .word_count(cnt_a));
  endian_unswap48_rx #(.MSB_FIRST(1), .BIT_REVERSE(1), .COUNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .err_short(err_b), .word_count(cnt_b));
  endian_unswap48_rx #(.MSB_FIRST(0), .BIT_REVERSE(0), .COUNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .err_short(err_c), .word_count(cnt_c));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic last, output int stalls);
    bit done = 0;
    stalls = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (ifa.in_ready) done = 1;
      else stalls++;
      step();
    end
    if (!done) check_eq("accept_timeout", 64'(b), 64'hFFFF);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_word(input logic [47:0] w, input logic last_on_6);
    int s;
    logic [47:0] t;
    t = w;
    for (int k = 0; k < 6; k++) begin
      send_byte(t[47-8*k -: 8], (k == 5) ? last_on_6 : 1'b0, s);
    end
  endtask

  task automatic check_words(input string tag, input logic vld,
                             input logic [47:0] ea, input logic [47:0] eb, input logic [47:0] ec);
    check_eq({tag, "_vld_a"}, 64'(ifa.out_valid), 64'(vld));
    check_eq({tag, "_vld_c"}, 64'(ifc.out_valid), 64'(vld));
    check_eq({tag, "_word_a"}, 64'(ifa.out_word), 64'(ea));
    check_eq({tag, "_word_b"}, 64'(ifb.out_word), 64'(eb));
    check_eq({tag, "_word_c"}, 64'(ifc.out_word), 64'(ec));
  endtask

  initial begin
    int s;
    int stall_sum;

    #2;
    check_words("reset", 1'b0, 48'h0, 48'h0, 48'h0);
    check_eq("reset_err", 64'({err_a, err_b, err_c}), 64'h0);
    check_eq("reset_cnt_a", 64'(cnt_a), 64'h0);
    check_eq("reset_rdy", 64'(ifa.in_ready), 64'h0);
    #20;
    rst_n = 1'b1;
    #1;
    check_eq("rdy_before_clk", 64'(ifa.in_ready), 64'h0);
    step();
    check_eq("rdy_after_clk", 64'(ifa.in_ready), 64'h1);

    // Basic word, out_ready high.
    out_ready = 1'b1;
    send_word(48'h010203040506, 1'b1);
    check_words("w1", 1'b1, 48'h010203040506, 48'h60A020C04080, 48'h060504030201);
    step();
    check_words("w1_drain", 1'b0, 48'h010203040506, 48'h60A020C04080, 48'h060504030201);
    check_eq("w1_cnt_a", 64'(cnt_a), 64'd1);
    check_eq("w1_cnt_c", 64'(cnt_c), 64'd1);

    // Short frames: 3-byte frame, then a 1-byte frame from IDLE.
    send_byte(8'hAA, 1'b0, s);
    send_byte(8'hBB, 1'b0, s);
    send_byte(8'hCC, 1'b1, s);
    check_eq("short_err", 64'({err_a, err_b, err_c}), 64'h7);
    check_eq("short_novld", 64'(ifa.out_valid), 64'h0);
    step();
    check_eq("short_err_pulse", 64'(err_a), 64'h0);
    send_byte(8'h55, 1'b1, s);
    check_eq("short1_err", 64'(err_a), 64'h1);
    step();
    check_eq("short1_err_pulse", 64'(err_a), 64'h0);
    send_word(48'hAABBCCDDEEFF, 1'b1);
    check_words("w2", 1'b1, 48'hAABBCCDDEEFF, 48'hFF77BB33DD55, 48'hFFEEDDCCBBAA);
    step();
    check_eq("w2_cnt_a", 64'(cnt_a), 64'd2);

    // Backpressure, no in_last on byte 6.
    out_ready = 1'b0;
    send_word(48'h010203040506, 1'b0);
    check_words("bp1", 1'b1, 48'h010203040506, 48'h60A020C04080, 48'h060504030201);
    stall_sum = 0;
    for (int k = 7; k <= 11; k++) begin
      send_byte(8'(k), 1'b0, s);
      stall_sum += s;
    end
    check_eq("bp_no_stall", 64'(stall_sum), 64'd0);
    in_valid = 1'b1;
    in_data  = 8'h0C;
    @(negedge clk);
    check_eq("bp_stall0", 64'(ifa.in_ready), 64'h0);
    step();
    @(negedge clk);
    check_eq("bp_stall1", 64'(ifa.in_ready), 64'h0);
    check_words("bp_hold", 1'b1, 48'h010203040506, 48'h60A020C04080, 48'h060504030201);
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_rdy", 64'(ifa.in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check_words("bp2", 1'b1, 48'h0708090A0B0C, 48'h30D0509010E0, 48'h0C0B0A090807);
    check_eq("bp2_cnt_a", 64'(cnt_a), 64'd3);
    step();
    check_eq("bp2_drain", 64'(ifa.out_valid), 64'h0);
    check_eq("bp2_cnt_a4", 64'(cnt_a), 64'd4);
    check_eq("sat_cnt_c", 64'(cnt_c), 64'd3);

    send_word(48'h212223242526, 1'b1);
    check_words("w5", 1'b1, 48'h212223242526, 48'h64A424C44484, 48'h262524232221);
    step();
    check_eq("w5_cnt_a", 64'(cnt_a), 64'd5);
    check_eq("w5_cnt_b", 64'(cnt_b), 64'd5);
    check_eq("sat_hold_c", 64'(cnt_c), 64'd3);

    // Reset with a pending word and a partial word in flight.
    out_ready = 1'b0;
    send_word(48'h313233343536, 1'b0);
    send_byte(8'h41, 1'b0, s);
    send_byte(8'h42, 1'b0, s);
    send_byte(8'h43, 1'b0, s);
    check_eq("pre_rst_vld", 64'(ifa.out_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_words("mid_rst", 1'b0, 48'h0, 48'h0, 48'h0);
    check_eq("mid_rst_cnt", 64'(cnt_a), 64'h0);
    check_eq("mid_rst_rdy", 64'(ifa.in_ready), 64'h0);
    #3;
    rst_n = 1'b1;
    step();
    check_eq("post_rst_rdy", 64'(ifa.in_ready), 64'h1);
    check_eq("post_rst_vld", 64'(ifa.out_valid), 64'h0);
    out_ready = 1'b1;
    send_word(48'h111213141516, 1'b1);
    check_words("w_rst", 1'b1, 48'h111213141516, 48'h68A828C84888, 48'h161514131211);
    step();
    check_eq("w_rst_cnt_a", 64'(cnt_a), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout got %0t exp finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/endian_unswap48_rx.md
Name: endian_unswap48_rx

Overview:
- Receive-side counterpart of the 48-bit endian-swap path.
- Accepts a byte-serial stream carrying 48-bit words (6 bytes per word), reassembles each word, optionally undoes the full 48-bit bit reversal, and presents the word on a valid/ready output.
- Sits between the byte-wide transport (UART/SPI front end) and the 48-bit key/data consumers of the crypto datapath, e.g. DES round-key logic.

Parameters:
- MSB_FIRST, 1, 1 = first received byte lands in bits [47:40]; 0 = first byte lands in bits [7:0].
- BIT_REVERSE, 1, 1 = output word bit i = assembled bit 47-i; 0 = pass-through.
- COUNT_W, 16, width of the saturating delivered-word counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  byte stream data.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks final byte of a word; qualified by in_valid.
- in_ready  output  1  block can accept a byte this cycle.
- out_word  output  48  reassembled (optionally unswapped) word.
- out_valid  output  1  out_word valid.
- out_ready  input  1  consumer accepts out_word.
- err_short  output  1  one-cycle pulse: in_last seen before byte 6.
- word_count  output  COUNT_W  words delivered (out handshakes), saturating.

Behaviour:
- Reset (async assert, sync deassert by design): out_valid=0, out_word=0, err_short=0, word_count=0, byte index=0, FSM=IDLE. in_ready is 0 while rst_n is low and 1 on the first clock after release.
- Byte accept means in_valid & in_ready. Output accept means out_valid & out_ready.
- Two registers: a 48-bit assembly register and the 48-bit output register. The next word can be collected while the previous word waits.
- FSM states:
  - IDLE: index=0. Accept moves to COLLECT, or reloads IDLE if in_last (short-frame case).
  - COLLECT: index 1..5. Completion and short-frame handling follow the rules below.
- Byte placement: MSB_FIRST=1 puts byte k (k=0..5) into bits [47-8k -: 8]. MSB_FIRST=0 puts it into bits [8k +: 8].
- in_ready = !(index==5 && out_valid && !out_ready). Only the completing byte is stalled; bytes 0..4 are always accepted.
- Completion: on accept of byte 5, the output register loads the final word (with BIT_REVERSE applied) on the same edge. out_valid=1 the next cycle, so latency is 1 cycle from the 6th byte accept. Index returns to 0 and the FSM goes to IDLE.
- Simultaneous output accept and completion in the same cycle: the output register reloads with the new word and out_valid stays 1 with no bubble.
- Output accept with no completion: out_valid=0 next cycle. out_word holds its last value.
- in_last with index<5: the partial word is discarded, index resets to 0, the FSM goes to IDLE, and err_short=1 for exactly the next cycle. The output register is untouched.
- Byte 5 without in_last: the word is delivered normally. in_last is not required on byte 5.
- word_count increments on each output accept and saturates at 2^COUNT_W-1 with no wrap.
- Reset mid-word: the partial word and any pending output are lost, and no out_valid is produced for them.
- in_data and in_last are ignored when in_valid=0.

Decomposition:
- Shared package endian48_pkg:
  - WORD_W=48, BYTE_W=8, BYTES_PER_WORD=6.
  - FSM state typedef {IDLE, COLLECT}.
  - bit_reverse48 function, shared with the existing swap logic so both directions use one definition.
- One natural sub-module, byte_placer48: combinational insertion of byte k into the assembly word per MSB_FIRST. The remainder is a single module.

Test Plan:
- MSB_FIRST=1, BIT_REVERSE=0; bytes 01 02 03 04 05 06 (last on 06), out_ready=1 -> out_word=0x010203040506 one cycle after byte 06; word_count=1.
- MSB_FIRST=1, BIT_REVERSE=1; same bytes -> out_word=0x60A020C04080.
- Short frame: bytes AA BB CC with last on CC -> err_short single-cycle pulse, no out_valid. Then AA..FF (6 bytes) -> out_word=0xAABBCCDDEEFF (BIT_REVERSE=0).
- Backpressure: out_ready=0, stream 12 bytes 01..0C -> first word 0x010203040506 held. in_ready=0 only while byte 0C is presented. Raise out_ready -> 0x010203040506 then 0x0708090A0B0C, in order, no loss, no bubble between them.
- Reset mid-word: 3 bytes, pulse rst_n low asynchronously (between edges) -> out_valid=0 immediately. Then bytes 11..16 -> 0x111213141516.
- COUNT_W=2, 5 words delivered -> word_count=3 and holds at 3.
